// File: rtl/mixer_pkg.sv
// mixer_pkg: types and constants shared by the
// coefficient calculator, the ramp and the mixer MAC.
package mixer_pkg;

   localparam int NCH     = 16;
   localparam int COEFF_W = 16;
   localparam int FLAT_W  = NCH * COEFF_W;
   localparam int CH_W    = 4;

   typedef logic signed [COEFF_W-1:0] coeff_t;

   typedef enum logic {
      ST_IDLE,
      ST_SWEEP
   } ramp_st_e;

   // low bit of channel k inside a flat coefficient bus
   function automatic int unsigned slc_lo(input int unsigned k);
      return k * COEFF_W;
   endfunction

endpackage

// File: rtl/coeff_slew_step.sv
// coeff_slew_step: one slew-limited move of a single
// coefficient toward its target, plus arrival flag.
module coeff_slew_step
   import mixer_pkg::*;
#(
   parameter logic [COEFF_W-1:0] STEP = 16'd64
) (
   input  logic [COEFF_W-1:0] i_cur,
   input  logic [COEFF_W-1:0] i_tgt,
   output logic [COEFF_W-1:0] o_next,
   output logic               o_eq
);

   logic signed [COEFF_W:0] w_d;
   logic signed [COEFF_W:0] w_neg;
   logic        [COEFF_W:0] w_mag;
   logic        [COEFF_W:0] w_step;

   assign w_d    = $signed({i_tgt[COEFF_W-1], i_tgt})
                 - $signed({i_cur[COEFF_W-1], i_cur});
   assign w_neg  = -w_d;
   assign w_mag  = w_d[COEFF_W] ? $unsigned(w_neg)
                                : $unsigned(w_d);
   assign w_step = {1'b0, STEP};

   // land on target when close, else move one STEP toward it
   always_comb begin
      if (w_mag <= w_step) begin
         o_next = i_tgt;
      end else if (!w_d[COEFF_W]) begin
         o_next = i_cur + STEP;
      end else begin
         o_next = i_cur - STEP;
      end
   end

   assign o_eq = (o_next == i_tgt);

endmodule

// File: rtl/coeff_ramp16.sv
// coeff_ramp16: 16-channel L/R coefficient slew limiter
// between the coefficient calculator and the mixer MAC.
module coeff_ramp16
   import mixer_pkg::*;
#(
   parameter logic [COEFF_W-1:0] STEP = 16'd64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_tick,
   input  logic              coeff_done,
   input  logic              snap,
   input  logic [FLAT_W-1:0] tgt_L_flat,
   input  logic [FLAT_W-1:0] tgt_R_flat,
   output logic [FLAT_W-1:0] cur_L_flat,
   output logic [FLAT_W-1:0] cur_R_flat,
   output logic              ramp_busy,
   output logic              settled,
   output logic              overrun,
   input  logic              overrun_clr
);

   coeff_t r_pend_l [NCH];
   coeff_t r_pend_r [NCH];
   coeff_t r_act_l  [NCH];
   coeff_t r_act_r  [NCH];
   coeff_t r_cur_l  [NCH];
   coeff_t r_cur_r  [NCH];

   coeff_t w_in_l   [NCH];
   coeff_t w_in_r   [NCH];
   coeff_t w_src_l  [NCH];
   coeff_t w_src_r  [NCH];

   ramp_st_e          r_state;
   logic [CH_W-1:0]   r_ch;
   logic              r_all_eq;
   logic              r_dirty;
   logic              r_busy;
   logic              r_settled;
   logic              r_overrun;

   logic [COEFF_W-1:0] w_next_l;
   logic [COEFF_W-1:0] w_next_r;
   logic               w_eq_l;
   logic               w_eq_r;
   logic               w_all_eq;
   logic               w_last;
   logic               w_sweep;

   for (genvar k = 0; k < NCH; k++) begin : g_flat
      assign w_in_l[k] = tgt_L_flat[slc_lo(k) +: COEFF_W];
      assign w_in_r[k] = tgt_R_flat[slc_lo(k) +: COEFF_W];
      assign cur_L_flat[slc_lo(k) +: COEFF_W] = r_cur_l[k];
      assign cur_R_flat[slc_lo(k) +: COEFF_W] = r_cur_r[k];
   end

   // targets to load: bypass the pend store on a same-cycle done
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         w_src_l[k] = coeff_done ? w_in_l[k] : r_pend_l[k];
         w_src_r[k] = coeff_done ? w_in_r[k] : r_pend_r[k];
      end
   end

   coeff_slew_step #(
      .STEP   (STEP)
   ) u_step_l (
      .i_cur  (r_cur_l[r_ch]),
      .i_tgt  (r_act_l[r_ch]),
      .o_next (w_next_l),
      .o_eq   (w_eq_l)
   );

   coeff_slew_step #(
      .STEP   (STEP)
   ) u_step_r (
      .i_cur  (r_cur_r[r_ch]),
      .i_tgt  (r_act_r[r_ch]),
      .o_next (w_next_r),
      .o_eq   (w_eq_r)
   );

   assign w_all_eq = r_all_eq & w_eq_l & w_eq_r;
   assign w_last   = (r_ch == CH_W'(NCH - 1));
   assign w_sweep  = (r_state == ST_SWEEP);

   // pending-target capture, independent of the sweep FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            r_pend_l[k] <= '0;
            r_pend_r[k] <= '0;
         end
      end else if (coeff_done) begin
         for (int k = 0; k < NCH; k++) begin
            r_pend_l[k] <= w_in_l[k];
            r_pend_r[k] <= w_in_r[k];
         end
      end
   end

   // sticky overrun: ticks that land on a running sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
      end else if (sample_tick && w_sweep && !snap) begin
         r_overrun <= 1'b1;
      end
   end

   // sweep FSM: one channel pair per cycle, snap overrides all
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) begin
            r_act_l[k] <= '0;
            r_act_r[k] <= '0;
            r_cur_l[k] <= '0;
            r_cur_r[k] <= '0;
         end
         r_state   <= ST_IDLE;
         r_ch      <= '0;
         r_all_eq  <= 1'b1;
         r_dirty   <= 1'b0;
         r_busy    <= 1'b0;
         r_settled <= 1'b1;
      end else if (snap) begin
         for (int k = 0; k < NCH; k++) begin
            r_act_l[k] <= w_src_l[k];
            r_act_r[k] <= w_src_r[k];
            r_cur_l[k] <= w_src_l[k];
            r_cur_r[k] <= w_src_r[k];
         end
         r_state   <= ST_IDLE;
         r_ch      <= '0;
         r_all_eq  <= 1'b1;
         r_dirty   <= 1'b0;
         r_busy    <= 1'b0;
         r_settled <= 1'b1;
      end else begin
         unique case (1'b1)
            (r_state == ST_IDLE): begin
               if (coeff_done) begin
                  r_settled <= 1'b0;
               end
               if (sample_tick) begin
                  for (int k = 0; k < NCH; k++) begin
                     r_act_l[k] <= w_src_l[k];
                     r_act_r[k] <= w_src_r[k];
                  end
                  r_state  <= ST_SWEEP;
                  r_ch     <= '0;
                  r_all_eq <= 1'b1;
                  r_dirty  <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            (r_state == ST_SWEEP): begin
               r_cur_l[r_ch] <= w_next_l;
               r_cur_r[r_ch] <= w_next_r;
               if (coeff_done) begin
                  r_dirty   <= 1'b1;
                  r_settled <= 1'b0;
               end
               if (w_last) begin
                  r_state   <= ST_IDLE;
                  r_ch      <= '0;
                  r_all_eq  <= 1'b1;
                  r_busy    <= 1'b0;
                  r_settled <= w_all_eq & ~r_dirty & ~coeff_done;
               end else begin
                  r_ch     <= r_ch + CH_W'(1);
                  r_all_eq <= w_all_eq;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ramp_busy = r_busy;
   assign settled   = r_settled;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_coeff_ramp16.sv
// tb_coeff_ramp16: randomized and directed checks of the
// coefficient ramp against a whole-sweep behavioural model.
module tb_coeff_ramp16;

   localparam int STEP = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         sample_tick = 1'b0;
   logic         coeff_done = 1'b0;
   logic         snap = 1'b0;
   logic         overrun_clr = 1'b0;
   logic [255:0] tgt_L_flat = '0;
   logic [255:0] tgt_R_flat = '0;
   logic [255:0] cur_L_flat;
   logic [255:0] cur_R_flat;
   logic         ramp_busy;
   logic         settled;
   logic         overrun;

   always #5 clk = ~clk;

   coeff_ramp16 #(
      .STEP        (16'd64)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .coeff_done  (coeff_done),
      .snap        (snap),
      .tgt_L_flat  (tgt_L_flat),
      .tgt_R_flat  (tgt_R_flat),
      .cur_L_flat  (cur_L_flat),
      .cur_R_flat  (cur_R_flat),
      .ramp_busy   (ramp_busy),
      .settled     (settled),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   int n_chk  = 0;
   int n_fail = 0;

   int m_pend_l [16];
   int m_pend_r [16];
   int m_act_l  [16];
   int m_act_r  [16];
   int m_cur_l  [16];
   int m_cur_r  [16];
   int m_set;
   int n_l [16];
   int n_r [16];

   task automatic check(input string tag, input int got,
                        input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
      end
   endtask

   function automatic int cur_l(input int k);
      logic signed [15:0] v;
      v = cur_L_flat[k*16 +: 16];
      return int'(v);
   endfunction

   function automatic int cur_r(input int k);
      logic signed [15:0] v;
      v = cur_R_flat[k*16 +: 16];
      return int'(v);
   endfunction

   function automatic int stp(input int c, input int t);
      int d;
      d = t - c;
      if (d <= STEP && d >= -STEP) return t;
      return (d > 0) ? c + STEP : c - STEP;
   endfunction

   function automatic int rnd16();
      logic signed [15:0] v;
      v = 16'($urandom);
      return int'(v);
   endfunction

   function automatic int near(input int c);
      int v;
      v = c + int'($urandom_range(0, 300)) - 150;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return v;
   endfunction

   task automatic step1();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 16; k++) begin
         m_pend_l[k] = 0; m_pend_r[k] = 0;
         m_act_l[k]  = 0; m_act_r[k]  = 0;
         m_cur_l[k]  = 0; m_cur_r[k]  = 0;
      end
      m_set = 1;
   endtask

   task automatic model_sweep();
      int ok;
      ok = 1;
      for (int k = 0; k < 16; k++) begin
         m_act_l[k] = m_pend_l[k];
         m_act_r[k] = m_pend_r[k];
         m_cur_l[k] = stp(m_cur_l[k], m_act_l[k]);
         m_cur_r[k] = stp(m_cur_r[k], m_act_r[k]);
         if (m_cur_l[k] != m_act_l[k]) ok = 0;
         if (m_cur_r[k] != m_act_r[k]) ok = 0;
      end
      m_set = ok;
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("%s_L%0d", tag, k), cur_l(k), m_cur_l[k]);
         check($sformatf("%s_R%0d", tag, k), cur_r(k), m_cur_r[k]);
      end
      check({tag, "_settled"}, int'(settled), m_set);
   endtask

   task automatic pack_n();
      for (int k = 0; k < 16; k++) begin
         tgt_L_flat[k*16 +: 16] = 16'(n_l[k]);
         tgt_R_flat[k*16 +: 16] = 16'(n_r[k]);
      end
   endtask

   task automatic do_load();
      pack_n();
      coeff_done = 1'b1;
      step1();
      coeff_done = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_pend_l[k] = n_l[k];
         m_pend_r[k] = n_r[k];
      end
      m_set = 0;
      check("load_settled", int'(settled), 0);
   endtask

   task automatic do_snap();
      snap = 1'b1;
      step1();
      snap = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_act_l[k] = m_pend_l[k]; m_cur_l[k] = m_pend_l[k];
         m_act_r[k] = m_pend_r[k]; m_cur_r[k] = m_pend_r[k];
      end
      m_set = 1;
      check("snap_busy", int'(ramp_busy), 0);
      check_all("snap");
   endtask

   task automatic do_tick();
      int old1;
      sample_tick = 1'b1;
      step1();
      sample_tick = 1'b0;
      check("busy_start", int'(ramp_busy), 1);
      old1 = m_cur_l[1];
      model_sweep();
      step1();
      check("ch0_first", cur_l(0), m_cur_l[0]);
      check("ch1_wait", cur_l(1), old1);
      repeat (14) step1();
      check("busy_last", int'(ramp_busy), 1);
      step1();
      check("busy_end", int'(ramp_busy), 0);
      check_all("tick");
   endtask

   task automatic near_all();
      for (int k = 0; k < 16; k++) begin
         n_l[k] = near(m_cur_l[k]);
         n_r[k] = near(m_cur_r[k]);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) step1();
      check("rst_busy", int'(ramp_busy), 0);
      check("rst_ovr", int'(overrun), 0);
      check_all("rst");
      rst_n = 1'b1;
      step1();

      // full ramp 0 -> 16384, ticks 64 cycles apart
      for (int k = 0; k < 16; k++) begin
         n_l[k] = 0; n_r[k] = 0;
      end
      n_l[0] = 16384;
      do_load();
      for (int i = 1; i <= 256; i++) begin
         do_tick();
         check("ramp_ch0", cur_l(0), 64 * i);
         check("ramp_settled", int'(settled), int'(i == 256));
         repeat (64 - 17) step1();
      end

      // down-ramp with a residual below STEP
      n_l[0] = 1000;
      do_load();
      do_snap();
      n_l[0] = 970;
      do_load();
      do_tick();
      check("down_970", cur_l(0), 970);
      check("down_settled", int'(settled), 1);

      // ticks 10 cycles apart: every second one dropped
      near_all();
      do_load();
      for (int e = 0; e <= 36; e++) begin
         sample_tick = (e % 10 == 0) && (e <= 30);
         overrun_clr = (e == 30);
         step1();
         if (e == 0 || e == 20) model_sweep();
         if (e == 10) check("ovr_set", int'(overrun), 1);
         if (e == 20) check("ovr_sticky", int'(overrun), 1);
         if (e == 30) check("ovr_clr_prio", int'(overrun), 0);
      end
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      check("ovr_busy", int'(ramp_busy), 0);
      check_all("ovr");

      // new targets mid-sweep: sweep keeps the old act
      near_all();
      do_load();
      sample_tick = 1'b1;
      step1();
      sample_tick = 1'b0;
      model_sweep();
      repeat (5) step1();
      for (int k = 0; k < 16; k++) begin
         n_l[k] = rnd16();
         n_r[k] = rnd16();
      end
      pack_n();
      coeff_done = 1'b1;
      step1();
      coeff_done = 1'b0;
      for (int k = 0; k < 16; k++) begin
         m_pend_l[k] = n_l[k];
         m_pend_r[k] = n_r[k];
      end
      repeat (10) step1();
      m_set = 0;
      check("mid_busy", int'(ramp_busy), 0);
      check_all("mid");
      do_tick();

      // snap during a sweep
      near_all();
      n_r[3] = 32'h2D41;
      do_load();
      sample_tick = 1'b1;
      step1();
      sample_tick = 1'b0;
      repeat (4) step1();
      do_snap();
      check("snap_r3", cur_r(3), 32'h2D41);
      check("snap_settled", int'(settled), 1);

      // randomized load / tick / snap mix
      for (int it = 0; it < 80; it++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op <= 3) begin
            if ($urandom_range(0, 1) == 1) begin
               near_all();
            end else begin
               for (int k = 0; k < 16; k++) begin
                  n_l[k] = rnd16();
                  n_r[k] = rnd16();
               end
            end
            do_load();
         end else if (op <= 8) begin
            do_tick();
         end else begin
            do_snap();
         end
         repeat ($urandom_range(0, 3)) step1();
      end
      check("rand_ovr", int'(overrun), 0);

      // asynchronous reset in the middle of a sweep
      near_all();
      do_load();
      sample_tick = 1'b1;
      step1();
      sample_tick = 1'b0;
      repeat (5) step1();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_busy", int'(ramp_busy), 0);
      check("arst_ovr", int'(overrun), 0);
      check_all("arst");
      step1();
      step1();
      rst_n = 1'b1;
      step1();
      near_all();
      do_load();
      do_tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/coeff_ramp16.md
# coeff_ramp16

Per-channel coefficient slew limiter that consumes the 16 L/R gain-pan coefficient pairs from the coefficient calculator and delivers zipper-free coefficients to the mixer datapath. It captures new targets on the calculator's `done` pulse. On each audio sample tick it moves every current coefficient toward its target by at most `STEP` LSBs. It sits between the coefficient calculator and the 16-channel mixer MAC.

## Interface
- `NCH`, 16: number of channels (fixed; the flat-bus widths below assume 16).
- `COEFF_W`, 16: coefficient width, signed Q2.14.
- `STEP`, 16'd64: maximum change per channel per sample tick, in LSBs; must be >0.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sample_tick` in 1: 1-cycle pulse, one per audio frame.
- `coeff_done` in 1: 1-cycle pulse from the calculator; target buses are valid in this cycle.
- `snap` in 1: 1-cycle pulse; jump all outputs to targets immediately.
- `tgt_L_flat` in 256: targets; channel k occupies [16k+15:16k].
- `tgt_R_flat` in 256: same layout as `tgt_L_flat`.
- `cur_L_flat` out 256: registered current coefficients, same layout.
- `cur_R_flat` out 256: registered current coefficients, same layout.
- `ramp_busy` out 1: sweep in progress.
- `settled` out 1: every output equals its target.
- `overrun` out 1: sticky; a tick arrived while a sweep was running.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- Storage: `pend` array (32×16) and `act` array (32×16) for targets; `cur` array (32×16).
- Capture: on `coeff_done`, `pend` <= the tgt buses and `settled` <= 0.
- FSM IDLE:
  - On `sample_tick`: `act` <= `pend`; `ch` <= 0; go to SWEEP.
  - If `coeff_done` is high in the same cycle, the newly captured values are used (bypass).
- FSM SWEEP, one channel per cycle, L and R in parallel: `cur[ch]` <= step(`cur[ch]`, `act[ch]`).
  - The `all_eq` accumulator is AND-ed with the equality result for each channel.
  - At `ch`==15 return to IDLE. `settled` <= `all_eq`, unless `coeff_done` occurred during the sweep, in which case `settled` stays 0.
- Step arithmetic: d = tgt − cur in 17-bit signed.
  - If |d| ≤ STEP, the result is tgt.
  - Else if d > 0, the result is cur+STEP; otherwise cur−STEP.
  - The result always lies between cur and tgt, so no overflow or saturation is needed.
- `sample_tick` while SWEEP: the tick is dropped, `overrun` <= 1, and the sweep continues.
- `snap`, any state: `act` and `cur` <= `pend`, or the incoming buses if `coeff_done` is high in the same cycle.
  - `settled` <= 1, FSM -> IDLE, `ramp_busy` <= 0.
  - `snap` has priority over `sample_tick` and over a running sweep.
- `overrun_clr` has priority over a simultaneous set.
- Reset (asynchronous, any time including mid-sweep):
  - `cur`, `act`, `pend` = 0.
  - `settled` = 1, `ramp_busy` = 0, `overrun` = 0, FSM IDLE, `ch` = 0.

## Timing
- Tick sampled at edge T: `ramp_busy` is high for the 16 cycles T+1..T+16.
- Channel k's outputs update at the edge ending cycle T+1+k.
- `settled` updates at the edge ending cycle T+16.
- Minimum tick spacing without overrun: 17 cycles.
- `coeff_done` -> `pend` valid 1 cycle later; no effect on outputs until the next tick or snap.
- `snap` -> all outputs updated 1 cycle later.
- Full ramp from 0 to 16384 at STEP 64 takes 256 ticks.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `mixer_pkg` holds:
  - `NCH`, `COEFF_W`;
  - the `coeff_t` typedef (signed [15:0]);
  - the flat-bus slice index helper, also used by the calculator and the mixer.
- Sub-module `coeff_slew_step`: combinational single-coefficient step (cur, tgt, STEP -> next, eq).
  - Instantiate it twice (L and R), muxed by `ch`.

## Test plan
- Reset, then a `coeff_done` load of ch0 L = 16384 with all else 0, then ticks 64 cycles apart:
  - `cur` ch0 L reads 64, 128, …; after tick 256 it reads 16384.
  - `settled` rises at the end of sweep 256, not earlier.
- Down-ramp with a non-multiple residual: cur = 1000, tgt = 970, STEP 64 -> 970 after one tick; `settled` = 1.
- Ticks 10 cycles apart:
  - Every second tick is dropped and `overrun` = 1.
  - Pulse `overrun_clr` together with a new overrun -> `overrun` = 0.
- `coeff_done` at sweep cycle ch = 5 with new targets:
  - The current sweep still uses the old `act`.
  - `settled` = 0 after the sweep.
  - The next tick ramps toward the new targets.
- `snap` during a sweep with `pend` ch3 R = 0x2D41:
  - Next cycle `cur_R` ch3 = 0x2D41, `ramp_busy` = 0, `settled` = 1.
- Deassert `rst_n` mid-sweep:
  - All outputs 0 immediately (asynchronously), `settled` = 1, `overrun` = 0.
  - After release, the first tick performs a normal 16-cycle sweep.
